// File: rtl/beat_pkg.sv
// ============================================================================
// beat_pkg : shared types and musical constants for the beat sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package beat_pkg;

    localparam int CROTCHETS_PER_PHRASE = 8;
    localparam int NUM_PHRASES          = 13;
    localparam int FRAME_CYCLES         = 420000;
    localparam int FRAMES_PER_CROTCHET  = 52;

    typedef logic [6:0] crotchet_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } beat_state_t;

    function automatic logic is_phrase_start(crotchet_t c);
        return (c[2:0] == 3'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tempo_divider.sv
// ============================================================================
// tempo_divider : crotchet-period counter with registered terminal/mid ticks.
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tempo_divider #(
    parameter int CROTCHET_CYCLES = 21840000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic term_tick,
    output logic mid_tick
);

    localparam int               DIV_W = $clog2(CROTCHET_CYCLES);
    localparam logic [DIV_W-1:0] LAST  = DIV_W'(CROTCHET_CYCLES - 1);
    localparam logic [DIV_W-1:0] MID   = DIV_W'(CROTCHET_CYCLES / 2 - 1);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] count_next;

    always_comb begin
        count_next = (count == LAST) ? '0 : count + DIV_W'(1);
    end

    // Ticks flag the cycle in which count sits on the event value, so they
    // stay asserted while the count is frozen and fire once it resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            term_tick <= 1'b0;
            mid_tick  <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            term_tick <= 1'b0;
            mid_tick  <= 1'b0;
        end else if (enable) begin
            count     <= count_next;
            term_tick <= (count_next == LAST);
            mid_tick  <= (count_next == MID);
        end
    end

endmodule

`default_nettype wire

// File: rtl/beat_sequencer.sv
// ============================================================================
// beat_sequencer : crotchet index sequencer with start/pause and beat pulses.
// Option         : BEAT_SEQUENCER_LOOP_EN wraps to crotchet 0 instead of DONE.
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_sequencer
    import beat_pkg::*;
#(
    parameter int CROTCHET_CYCLES = FRAMES_PER_CROTCHET * FRAME_CYCLES,
    parameter int NUM_CROTCHETS   = NUM_PHRASES * CROTCHETS_PER_PHRASE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    output logic [6:0] crotchet,
    output logic       crotchet_pulse,
    output logic       quaver_pulse,
    output logic       phrase_pulse,
    output logic       playing,
    output logic       done
);

    localparam crotchet_t LAST_CROTCHET = crotchet_t'(NUM_CROTCHETS - 1);

    beat_state_t state;
    logic        advancing;
    logic        term_tick;
    logic        mid_tick;
    crotchet_t   crotchet_next;

    // PAUSE with pause released behaves as RUN so held events fire at once.
    assign advancing     = ((state == RUN) || (state == PAUSE)) && !pause;
    assign crotchet_next = crotchet + 7'd1;

    tempo_divider #(
        .CROTCHET_CYCLES (CROTCHET_CYCLES)
    ) u_tempo_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (advancing && !start),
        .clear     (start),
        .term_tick (term_tick),
        .mid_tick  (mid_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            crotchet       <= '0;
            crotchet_pulse <= 1'b0;
            quaver_pulse   <= 1'b0;
            phrase_pulse   <= 1'b0;
            playing        <= 1'b0;
            done           <= 1'b0;
        end else begin
            crotchet_pulse <= 1'b0;
            quaver_pulse   <= 1'b0;
            phrase_pulse   <= 1'b0;
            if (start) begin
                state          <= RUN;
                crotchet       <= '0;
                crotchet_pulse <= 1'b1;
                phrase_pulse   <= 1'b1;
                playing        <= 1'b1;
                done           <= 1'b0;
            end else begin
                case (state)
                    RUN, PAUSE: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else begin
                            state        <= RUN;
                            quaver_pulse <= mid_tick;
                            if (term_tick) begin
                                if (crotchet != LAST_CROTCHET) begin
                                    crotchet       <= crotchet_next;
                                    crotchet_pulse <= 1'b1;
                                    phrase_pulse   <= is_phrase_start(crotchet_next);
                                end else begin
`ifdef BEAT_SEQUENCER_LOOP_EN
                                    crotchet       <= '0;
                                    crotchet_pulse <= 1'b1;
                                    phrase_pulse   <= 1'b1;
`else
                                    state          <= DONE;
                                    playing        <= 1'b0;
                                    done           <= 1'b1;
`endif
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Upstream timing source for the display renderer and music path.
- Divides the pixel clock into crotchet beats and sequences a crotchet index through the whole piece: 13 phrases of 8 crotchets.
- Outputs the index plus a one-cycle pulse per beat; the pulse drives frame-reset and frame-count decisions downstream.
- Provides start/pause control and phrase-boundary and quaver ticks.

Parameters:
- CROTCHET_CYCLES, 21840000, clock cycles per crotchet (52 frames × 420000 cycles/frame); must be even and ≥ 4.
- NUM_CROTCHETS, 104, crotchets in the piece; ≤ 128.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset.
- start  in  1  single-cycle request: (re)start the piece from crotchet 0.
- pause  in  1  level; freezes beat timing while high.
- crotchet  out  7  current crotchet index.
- crotchet_pulse  out  1  high for one cycle when crotchet takes a new value, including the restart to 0.
- quaver_pulse  out  1  high for one cycle at the mid-point of each crotchet.
- phrase_pulse  out  1  crotchet_pulse AND crotchet[2:0]==0.
- playing  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock is clk, reset is rst_n.
- All outputs are registered. Reset values:
  - state IDLE.
  - crotchet 0.
  - all pulses 0.
  - playing 0, done 0.
  - divider 0.
- States: IDLE, RUN, PAUSE, DONE.
- Divider width is $clog2(CROTCHET_CYCLES). It counts only in RUN, over 0..CROTCHET_CYCLES-1.
- start has highest priority in every state.
  - Cycle after start: state RUN, crotchet=0, crotchet_pulse=1, phrase_pulse=1, divider=0.
  - Applies mid-piece (restart) and from PAUSE or DONE.
  - start takes priority over a coincident terminal count and over pause.
- RUN, divider==CROTCHET_CYCLES/2-1: next cycle quaver_pulse=1.
- RUN, divider==CROTCHET_CYCLES-1: divider→0.
  - If crotchet<NUM_CROTCHETS-1: next cycle crotchet+1 with crotchet_pulse=1 in that same cycle.
  - If crotchet==NUM_CROTCHETS-1: see Optional Feature.
- Spacing: consecutive crotchet_pulses are exactly CROTCHET_CYCLES cycles apart while pause stays low.
- pause high in RUN: next state PAUSE, divider frozen at its current value, no pulses.
- pause low in PAUSE: back to RUN; the divider resumes from the frozen value.
- Pause and terminal/mid-point in the same cycle: pause wins. The divider holds at the event value, and the event fires on the first cycle after pause deasserts. No beat is lost; the beat is delayed by the pause duration.
- pause is ignored in IDLE and DONE.
- DONE: crotchet holds NUM_CROTCHETS-1, no pulses, done=1, playing=0. Only start or reset leaves DONE.
- IDLE: crotchet 0, no pulses. start is required to begin; there is no automatic start after reset.
- Reset asserted mid-piece returns to IDLE immediately (asynchronous); pulses are cleared in the same instant.

Optional Feature:
- Macro: BEAT_SEQUENCER_LOOP_EN.
- Defined: terminal count on the last crotchet wraps crotchet to 0 with crotchet_pulse=1 and phrase_pulse=1. The state stays RUN and DONE is never entered.
- Undefined: terminal count on the last crotchet enters DONE with no pulse. crotchet stays NUM_CROTCHETS-1.

Decomposition:
- Package beat_pkg:
  - crotchet_t (logic [6:0]).
  - beat_state_t enum {IDLE, RUN, PAUSE, DONE}.
  - CROTCHETS_PER_PHRASE=8, NUM_PHRASES=13, FRAME_CYCLES=420000.
- Sub-module tempo_divider:
  - Parameterised by CROTCHET_CYCLES.
  - Inputs: enable, clear.
  - Outputs: registered terminal tick and mid tick.
- beat_sequencer contains the FSM, the crotchet counter and the output registers.

Test Plan (CROTCHET_CYCLES=10, NUM_CROTCHETS=16 unless stated):
- Reset then start at cycle 5 → cycle 6: crotchet=0, crotchet_pulse=1, phrase_pulse=1; crotchet=1 pulse at cycle 16; quaver_pulse at cycle 11.
- Run to the end, macro undefined → the 15→DONE transition produces no pulse; done=1, crotchet=15 held for 100 cycles.
- Same run, macro defined → wrap to crotchet=0 with crotchet_pulse=1 and phrase_pulse=1 at cycle 6+160; done stays 0.
- pause high for 7 cycles, asserted on the terminal cycle of crotchet 2 → crotchet 3 pulse delayed exactly 7 cycles; spacing afterwards is back to 10.
- start asserted while crotchet=9 in RUN, coincident with terminal count → next cycle crotchet=0 with a single pulse; crotchet=10 is never output.
- Async rst_n low mid-cycle during crotchet 5 → outputs return to reset values without waiting for a clock edge; state IDLE after release.
